// File: rtl/sample_iterator.sv
// sample_iterator: walks the snapped bounding box of one triangle in raster
// order, emitting one sample location per clock to the sample-test stage.
// Upstream is held (halt) while a triangle is being iterated.
module sample_iterator #(
  parameter int SIGFIG = 24,
  parameter int RADIX  = 10,
  parameter int VERTS  = 3,
  parameter int AXIS   = 3,
  parameter int COLORS = 3
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [SIGFIG*VERTS*AXIS-1:0]    tri_R13S,
  input  logic [SIGFIG*COLORS-1:0]        color_R13U,
  input  logic [SIGFIG*4-1:0]             box_R13S,
  input  logic                            validTri_R13H,
  input  logic [3:0]                      subSample_RnnnnU,
  output logic                            halt_RnnnnH,
  output logic [SIGFIG*VERTS*AXIS-1:0]    tri_R14S,
  output logic [SIGFIG*COLORS-1:0]        color_R14U,
  output logic [2*SIGFIG-1:0]             sample_R14S,
  output logic                            validSamp_R14H
);

  typedef enum logic {WAIT, TEST} state_t;

  localparam logic [SIGFIG-1:0] ONE     = {{(SIGFIG-1){1'b0}}, 1'b1};
  localparam logic [SIGFIG-1:0] STEP_1  = ONE << RADIX;
  localparam logic [SIGFIG-1:0] STEP_4  = ONE << (RADIX - 1);
  localparam logic [SIGFIG-1:0] STEP_16 = ONE << (RADIX - 2);
  localparam logic [SIGFIG-1:0] STEP_64 = ONE << (RADIX - 3);

  state_t              state_reg;
  logic [SIGFIG-1:0]   llx_reg;
  logic [SIGFIG-1:0]   urx_reg;
  logic [SIGFIG-1:0]   ury_reg;
  logic [SIGFIG-1:0]   step_reg;

  logic [SIGFIG-1:0]   step_sel;
  logic [SIGFIG-1:0]   in_llx, in_lly, in_urx, in_ury;
  logic                degenerate;
  logic [SIGFIG-1:0]   cur_x, cur_y;
  logic signed [SIGFIG:0] next_x, next_y;
  logic                x_over, y_over;

  // Step size from the MSAA mode; anything not one-hot falls back to 1 spp.
  always_comb begin
    step_sel = STEP_1;
    case (subSample_RnnnnU)
      4'b0001: step_sel = STEP_1;
      4'b0010: step_sel = STEP_4;
      4'b0100: step_sel = STEP_16;
      4'b1000: step_sel = STEP_64;
      default: step_sel = STEP_1;
    endcase
  end

  // Unpack the incoming box and flag boxes with no samples (LL beyond UR).
  always_comb begin
    in_llx     = box_R13S[0*SIGFIG +: SIGFIG];
    in_lly     = box_R13S[1*SIGFIG +: SIGFIG];
    in_urx     = box_R13S[2*SIGFIG +: SIGFIG];
    in_ury     = box_R13S[3*SIGFIG +: SIGFIG];
    degenerate = ($signed(in_llx) > $signed(in_urx)) ||
                 ($signed(in_lly) > $signed(in_ury));
  end

  // Next-position arithmetic one bit wider than the coordinates so a box
  // edge near the positive limit cannot wrap into negative space.
  always_comb begin
    cur_x  = sample_R14S[0 +: SIGFIG];
    cur_y  = sample_R14S[SIGFIG +: SIGFIG];
    next_x = $signed({cur_x[SIGFIG-1], cur_x}) + $signed({1'b0, step_reg});
    next_y = $signed({cur_y[SIGFIG-1], cur_y}) + $signed({1'b0, step_reg});
    x_over = next_x > $signed({urx_reg[SIGFIG-1], urx_reg});
    y_over = next_y > $signed({ury_reg[SIGFIG-1], ury_reg});
  end

  // Iteration FSM with registered halt/valid outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= WAIT;
      llx_reg        <= '0;
      urx_reg        <= '0;
      ury_reg        <= '0;
      step_reg       <= '0;
      halt_RnnnnH    <= 1'b0;
      validSamp_R14H <= 1'b0;
      tri_R14S       <= '0;
      color_R14U     <= '0;
      sample_R14S    <= '0;
    end else begin
      case (state_reg)
        WAIT: begin
          if (validTri_R13H && !degenerate) begin
            tri_R14S       <= tri_R13S;
            color_R14U     <= color_R13U;
            llx_reg        <= in_llx;
            urx_reg        <= in_urx;
            ury_reg        <= in_ury;
            step_reg       <= step_sel;
            sample_R14S    <= {in_lly, in_llx};
            validSamp_R14H <= 1'b1;
            halt_RnnnnH    <= 1'b1;
            state_reg      <= TEST;
          end
        end
        TEST: begin
          if (x_over) begin
            if (y_over) begin
              // Current sample was the last one in the box.
              validSamp_R14H <= 1'b0;
              halt_RnnnnH    <= 1'b0;
              state_reg      <= WAIT;
            end else begin
              sample_R14S <= {next_y[SIGFIG-1:0], llx_reg};
            end
          end else begin
            sample_R14S[0 +: SIGFIG] <= next_x[SIGFIG-1:0];
          end
        end
        default: state_reg <= WAIT;
      endcase
    end
  end

endmodule

// File: tb/tb_sample_iterator.sv
// Testbench for sample_iterator: a driver issues triangles and pushes the
// expected sample stream into a queue; a monitor pops and compares each
// sample (position, triangle, colour, cycle of arrival, halt level).
module tb_sample_iterator;
  localparam int S  = 24;
  localparam int TW = S * 9;
  localparam int CW = S * 3;

  logic            clk = 1'b0;
  logic            rst;
  logic [TW-1:0]   tri_in;
  logic [CW-1:0]   col_in;
  logic [4*S-1:0]  box_in;
  logic            validTri;
  logic [3:0]      ss_in;
  logic            halt;
  logic [TW-1:0]   tri_out;
  logic [CW-1:0]   col_out;
  logic [2*S-1:0]  samp;
  logic            vsamp;

  sample_iterator #(.SIGFIG(S), .RADIX(10), .VERTS(3), .AXIS(3), .COLORS(3)) dut (
    .clk(clk), .rst(rst),
    .tri_R13S(tri_in), .color_R13U(col_in), .box_R13S(box_in),
    .validTri_R13H(validTri), .subSample_RnnnnU(ss_in),
    .halt_RnnnnH(halt), .tri_R14S(tri_out), .color_R14U(col_out),
    .sample_R14S(samp), .validSamp_R14H(vsamp)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            x;
    int            y;
    logic [TW-1:0] t;
    logic [CW-1:0] c;
    int            cyc;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  bit   sb_en = 1'b0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic chkw(input string name, input logic [TW-1:0] act, input logic [TW-1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  function automatic int sx(input logic [S-1:0] v);
    logic signed [S-1:0] s;
    s = v;
    return int'(s);
  endfunction

  // Reference step: bit k of a one-hot mode gives 1/2^k pixel, else 1 pixel.
  function automatic int step_of(input logic [3:0] ss);
    int st;
    st = 1024;
    if ($onehot(ss))
      for (int k = 0; k < 4; k++)
        if (ss[k]) st = 1024 >> k;
    return st;
  endfunction

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (sb_en) begin
      if (vsamp === 1'b1) begin
        if (sbq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_sample: got (%0d,%0d) want none", sx(samp[S-1:0]), sx(samp[2*S-1:S]));
        end else begin
          mon_e = sbq.pop_front();
          chk("samp_x", sx(samp[S-1:0]), mon_e.x);
          chk("samp_y", sx(samp[2*S-1:S]), mon_e.y);
          chk("samp_cycle", cyc, mon_e.cyc);
          chk("halt_busy", halt, 1);
          chkw("tri_out", tri_out, mon_e.t);
          chkw("color_out", TW'(col_out), TW'(mon_e.c));
        end
      end else begin
        chk("halt_idle", halt, 0);
      end
    end
  end

  // Drive one triangle once upstream is free; predict its samples.
  task automatic issue(input int llx, input int lly, input int urx, input int ury,
                       input logic [3:0] ss, input bit idle);
    int n;
    int st;
    int k;
    exp_t e;
    n = 0;
    while (halt !== 1'b0) begin
      @(negedge clk);
      n++;
      if (n > 3000) begin
        total++;
        bad++;
        $display("FAIL halt_timeout: halt still %b after %0d cycles, want 0", halt, n);
        break;
      end
    end
    if (idle) begin
      validTri = 1'b0;
      repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    for (int i = 0; i < TW; i++) tri_in[i] = 1'($urandom_range(0, 1));
    for (int i = 0; i < CW; i++) col_in[i] = 1'($urandom_range(0, 1));
    box_in   = {ury[S-1:0], urx[S-1:0], lly[S-1:0], llx[S-1:0]};
    ss_in    = ss;
    validTri = 1'b1;
    st = step_of(ss);
    k  = 0;
    for (int y = lly; y <= ury; y += st)
      for (int x = llx; x <= urx; x += st) begin
        e.x = x; e.y = y; e.t = tri_in; e.c = col_in; e.cyc = cyc + 1 + k;
        sbq.push_back(e);
        k++;
      end
    @(negedge clk);
  endtask

  initial begin
    logic [3:0] ss;
    int st, llx, lly, urx, ury, n;
    rst      = 1'b0;
    validTri = 1'b0;
    tri_in   = '0;
    col_in   = '0;
    box_in   = '0;
    ss_in    = 4'b0001;
    repeat (3) @(negedge clk);
    chk("rst_valid", vsamp, 0);
    chk("rst_halt", halt, 0);
    chk("rst_sample", samp, 0);
    chkw("rst_tri", tri_out, '0);
    chkw("rst_color", TW'(col_out), '0);
    rst = 1'b1;
    @(negedge clk);
    sb_en = 1'b1;

    // Directed boxes.
    issue(0, 0, 2048, 1024, 4'b0001, 0);
    issue(512, 512, 512, 512, 4'b0010, 0);
    issue(1024, 0, 0, 0, 4'b0001, 0);
    issue(-2048, -1024, 0, 0, 4'b0100, 0);
    issue(0, 0, 1024, 1024, 4'b0001, 0);
    issue(3072, 2048, 5120, 2048, 4'b0001, 0);
    issue(32'h7FF800, 5120, 32'h7FFC00, 5120, 4'b0001, 0);
    issue(0, 0, 1024, 0, 4'b0011, 0);

    // Random boxes on each mode's sample grid, some degenerate.
    for (int t = 0; t < 40; t++) begin
      case ($urandom_range(0, 4))
        0: ss = 4'b0001;
        1: ss = 4'b0010;
        2: ss = 4'b0100;
        3: ss = 4'b1000;
        default: ss = 4'($urandom_range(0, 15));
      endcase
      st  = step_of(ss);
      llx = ($urandom_range(0, 16) - 8) * st;
      lly = ($urandom_range(0, 16) - 8) * st;
      urx = llx + $urandom_range(0, 5) * st;
      ury = lly + $urandom_range(0, 4) * st;
      if ($urandom_range(0, 7) == 0) urx = llx - st;
      if ($urandom_range(0, 9) == 0) ury = lly - st;
      issue(llx, lly, urx, ury, ss, bit'($urandom_range(0, 1)));
    end
    validTri = 1'b0;

    n = 0;
    while (sbq.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    repeat (4) @(negedge clk);
    chk("queue_drained", sbq.size(), 0);
    sb_en = 1'b0;

    // Reset in the middle of a 64 spp row aborts it at once.
    box_in   = {24'd0, 24'd1024, 24'd0, 24'd0};
    ss_in    = 4'b1000;
    validTri = 1'b1;
    @(negedge clk);
    validTri = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("abort_valid", vsamp, 1);
      chk("abort_x", sx(samp[S-1:0]), 128 * i);
      if (i < 2) @(negedge clk);
    end
    #2 rst = 1'b0;
    #1;
    chk("async_valid", vsamp, 0);
    chk("async_halt", halt, 0);
    chk("async_sample", samp, 0);
    chkw("async_tri", tri_out, '0);
    @(negedge clk);
    rst = 1'b1;
    n = 0;
    repeat (12) begin
      @(negedge clk);
      if (vsamp !== 1'b0 || halt !== 1'b0) n++;
    end
    chk("post_reset_quiet", n, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
